// File: rtl/nps_capmem.sv
// nps_capmem: frame-capture memory with a 1-cycle stream pass-through and a
// registered CPU read port. Captures one vi/fi frame in one-shot or ring mode.
module nps_capmem #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 300,
  parameter int ADR_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset_x,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  ring,
  input  logic                  vi,
  input  logic                  fi,
  input  logic [DATA_WIDTH-1:0] datai,
  output logic                  vo,
  output logic                  fo,
  output logic [DATA_WIDTH-1:0] datao,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  wrapped,
  output logic [ADR_WIDTH:0]    wr_cnt,
  output logic [ADR_WIDTH-1:0]  wr_ptr,
  input  logic [ADR_WIDTH-1:0]  cpu_adr,
  input  logic                  cpu_rd,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_vld
);

  localparam logic [ADR_WIDTH-1:0] LAST_ADR = ADR_WIDTH'(DEPTH - 1);
  localparam logic [ADR_WIDTH:0]   FULL_CNT = (ADR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    ring_q, ring_d;
  logic                    ovf_q, ovf_d;
  logic                    wrapped_q, wrapped_d;
  logic                    ovf_watch_q, ovf_watch_d;
  logic [ADR_WIDTH:0]      wr_cnt_q, wr_cnt_d;
  logic [ADR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic                    vo_q, vo_d;
  logic                    fo_q, fo_d;
  logic [DATA_WIDTH-1:0]   datao_q, datao_d;
  logic                    cpu_vld_q, cpu_vld_d;
  logic [DATA_WIDTH-1:0]   cpu_data_q, cpu_data_d;
  logic                    mem_we;
  logic [ADR_WIDTH-1:0]    mem_adr;
  logic                    sof;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign sof = vi & fi;

  always_comb begin
    state_d     = state_q;
    ring_d      = ring_q;
    ovf_d       = ovf_q;
    wrapped_d   = wrapped_q;
    ovf_watch_d = ovf_watch_q;
    wr_cnt_d    = wr_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    mem_we      = 1'b0;
    mem_adr     = wr_ptr_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d     = S_ARMED;
            ring_d      = ring;
            ovf_d       = 1'b0;
            wrapped_d   = 1'b0;
            ovf_watch_d = 1'b0;
            wr_cnt_d    = '0;
            wr_ptr_d    = '0;
          end else if (state_q == S_DONE && ovf_watch_q && vi) begin
            // A one-shot frame that filled the RAM is watched until its sof.
            if (fi) ovf_watch_d = 1'b0;
            else    ovf_d       = 1'b1;
          end
        end
        S_ARMED: begin
          if (sof) begin
            state_d  = S_CAPTURE;
            mem_we   = 1'b1;
            mem_adr  = '0;
            wr_ptr_d = ADR_WIDTH'(1);
            wr_cnt_d = (ADR_WIDTH + 1)'(1);
          end
        end
        S_CAPTURE: begin
          if (sof) begin
            state_d = S_DONE;
          end else if (vi) begin
            mem_we   = 1'b1;
            wr_cnt_d = (wr_cnt_q == FULL_CNT) ? FULL_CNT : wr_cnt_q + 1'b1;
            if (wr_ptr_q != LAST_ADR) begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end else if (ring_q) begin
              wr_ptr_d  = '0;
              wrapped_d = 1'b1;
            end else begin
              state_d     = S_DONE;
              ovf_watch_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stream pass-through and CPU read; an out-of-range address reads as zero.
  always_comb begin
    vo_d       = vi;
    fo_d       = fi;
    datao_d    = datai;
    cpu_vld_d  = cpu_rd;
    cpu_data_d = cpu_data_q;
    if (cpu_rd) begin
      if ({1'b0, cpu_adr} < FULL_CNT) cpu_data_d = mem[cpu_adr];
      else                            cpu_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_x) begin
      state_q     <= S_IDLE;
      ring_q      <= 1'b0;
      ovf_q       <= 1'b0;
      wrapped_q   <= 1'b0;
      ovf_watch_q <= 1'b0;
      wr_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      vo_q        <= 1'b0;
      fo_q        <= 1'b0;
      datao_q     <= '0;
      cpu_vld_q   <= 1'b0;
      cpu_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ring_q      <= ring_d;
      ovf_q       <= ovf_d;
      wrapped_q   <= wrapped_d;
      ovf_watch_q <= ovf_watch_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      vo_q        <= vo_d;
      fo_q        <= fo_d;
      datao_q     <= datao_d;
      cpu_vld_q   <= cpu_vld_d;
      cpu_data_q  <= cpu_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset_x) mem[mem_adr] <= datai;
  end

  assign vo       = vo_q;
  assign fo       = fo_q;
  assign datao    = datao_q;
  assign busy     = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);
  assign ovf      = ovf_q;
  assign wrapped  = wrapped_q;
  assign wr_cnt   = wr_cnt_q;
  assign wr_ptr   = wr_ptr_q;
  assign cpu_data = cpu_data_q;
  assign cpu_vld  = cpu_vld_q;

endmodule

// File: tb/tb_nps_capmem.sv
// Self-checking bench for nps_capmem: a frame-level capture model checked every
// cycle, plus hand-computed literal expectations from directed scenarios.
module tb_nps_capmem;

  localparam int DW    = 24;
  localparam int DEPTH = 300;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          reset_x = 1'b1;
  logic          start = 1'b0, abort = 1'b0, ring = 1'b0;
  logic          vi = 1'b0, fi = 1'b0;
  logic [DW-1:0] datai = '0;
  logic          vo, fo, busy, done, ovf, wrapped, cpu_vld;
  logic [DW-1:0] datao, cpu_data;
  logic [AW:0]   wr_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] cpu_adr = '0;
  logic          cpu_rd = 1'b0;

  nps_capmem #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADR_WIDTH(AW)) dut (
    .clk(clk), .reset_x(reset_x), .start(start), .abort(abort), .ring(ring),
    .vi(vi), .fi(fi), .datai(datai), .vo(vo), .fo(fo), .datao(datao),
    .busy(busy), .done(done), .ovf(ovf), .wrapped(wrapped), .wr_cnt(wr_cnt),
    .wr_ptr(wr_ptr), .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_data(cpu_data),
    .cpu_vld(cpu_vld)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Frame-level model: phase, number of samples held, next slot, sticky flags.
  localparam int P_IDLE = 0, P_ARMED = 1, P_CAPTURE = 2, P_DONE = 3;
  int            m_phase = P_IDLE;
  int            m_count = 0;
  int            m_next = 0;
  bit            m_ring, m_ovf, m_wrapped, m_late, m_live;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  bit            e_vo, e_fo, e_cpu_vld, e_cpu_known;
  logic [DW-1:0] e_datao, e_cpu_data;

  always @(posedge clk) begin
    if (reset_x) begin
      m_phase = P_IDLE; m_count = 0; m_next = 0;
      m_ring = 0; m_ovf = 0; m_wrapped = 0; m_late = 0; m_live = 1;
      e_vo = 0; e_fo = 0; e_datao = '0; e_cpu_vld = 0; e_cpu_data = '0; e_cpu_known = 1;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    end else begin
      e_vo = vi; e_fo = fi; e_datao = datai;
      e_cpu_vld = cpu_rd;
      if (cpu_rd) begin
        if (int'(cpu_adr) < DEPTH) begin
          e_cpu_data = m_mem[cpu_adr]; e_cpu_known = m_known[cpu_adr];
        end else begin
          e_cpu_data = '0; e_cpu_known = 1;
        end
      end
      if (abort) begin
        m_phase = P_IDLE;
      end else if ((m_phase == P_IDLE || m_phase == P_DONE) && start) begin
        m_phase = P_ARMED; m_ring = ring; m_count = 0; m_next = 0;
        m_ovf = 0; m_wrapped = 0; m_late = 0;
      end else if (m_phase == P_DONE) begin
        if (m_late && vi) begin
          if (fi) m_late = 0;
          else    m_ovf = 1;
        end
      end else if (m_phase == P_ARMED) begin
        if (vi && fi) begin
          m_mem[0] = datai; m_known[0] = 1; m_next = 1; m_count = 1; m_phase = P_CAPTURE;
        end
      end else if (m_phase == P_CAPTURE && vi) begin
        if (fi) begin
          m_phase = P_DONE;
        end else begin
          m_mem[m_next] = datai; m_known[m_next] = 1;
          m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
          if (m_next < DEPTH - 1) m_next++;
          else if (m_ring) begin m_next = 0; m_wrapped = 1; end
          else begin m_phase = P_DONE; m_late = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("vo", 32'(vo), 32'(e_vo));
      checkOutput("fo", 32'(fo), 32'(e_fo));
      checkOutput("datao", 32'(datao), 32'(e_datao));
      checkOutput("busy", 32'(busy), 32'(m_phase == P_ARMED || m_phase == P_CAPTURE));
      checkOutput("done", 32'(done), 32'(m_phase == P_DONE));
      checkOutput("ovf", 32'(ovf), 32'(m_ovf));
      checkOutput("wrapped", 32'(wrapped), 32'(m_wrapped));
      checkOutput("wr_cnt", 32'(wr_cnt), 32'(m_count));
      checkOutput("wr_ptr", 32'(wr_ptr), 32'(m_next));
      checkOutput("cpu_vld", 32'(cpu_vld), 32'(e_cpu_vld));
      if (e_cpu_known) checkOutput("cpu_data", 32'(cpu_data), 32'(e_cpu_data));
    end
  end

  task automatic applyStimulus(input logic v, input logic f, input logic [DW-1:0] d);
    vi = v; fi = f; datai = d;
    @(negedge clk);
    start = 0; abort = 0; cpu_rd = 0;
  endtask

  task automatic cpuRead(input int adr, input int exp);
    cpu_rd = 1; cpu_adr = AW'(adr);
    applyStimulus(0, 0, '0);
    checkOutput("rd_vld", 32'(cpu_vld), 32'd1);
    checkOutput($sformatf("rd_data[%0d]", adr), 32'(cpu_data), 32'(exp));
  endtask

  initial begin
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    checkOutput("rst_cpu_data", 32'(cpu_data), 32'd0);
    reset_x = 0;

    // One-shot, 5-sample frame ended by the next sof.
    start = 1; ring = 0;
    applyStimulus(0, 0, '0);
    checkOutput("armed_busy", 32'(busy), 32'd1);
    applyStimulus(1, 1, 24'h10);
    for (int i = 1; i < 5; i++) applyStimulus(1, 0, DW'(24'h10 + i));
    applyStimulus(1, 1, 24'h99);
    applyStimulus(0, 0, '0);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_wr_cnt", 32'(wr_cnt), 32'd5);
    checkOutput("t1_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 5; i++) cpuRead(i, 'h10 + i);
    applyStimulus(0, 0, '0);
    checkOutput("t1_vld_drop", 32'(cpu_vld), 32'd0);

    // One-shot frame of 302 samples overflows DEPTH.
    start = 1; ring = 0;
    applyStimulus(0, 0, '0);
    applyStimulus(1, 1, '0);
    for (int i = 1; i < 302; i++) applyStimulus(1, 0, DW'(i));
    applyStimulus(0, 0, '0);
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_wr_cnt", 32'(wr_cnt), 32'd300);
    checkOutput("t2_ovf", 32'(ovf), 32'd1);
    cpuRead(299, 299);
    cpuRead(0, 0);

    // Ring mode; ring input dropped after arm to show it is latched.
    start = 1; ring = 1;
    applyStimulus(0, 0, '0);
    ring = 0;
    applyStimulus(1, 1, '0);
    for (int i = 1; i < 305; i++) applyStimulus(1, 0, DW'(i));
    applyStimulus(1, 1, 24'hFFF);
    applyStimulus(0, 0, '0);
    checkOutput("t3_wrapped", 32'(wrapped), 32'd1);
    checkOutput("t3_wr_cnt", 32'(wr_cnt), 32'd300);
    checkOutput("t3_wr_ptr", 32'(wr_ptr), 32'd5);
    checkOutput("t3_done", 32'(done), 32'd1);
    for (int i = 0; i < 5; i++) cpuRead(i, 300 + i);
    cpuRead(5, 5);

    // Non-sof samples while armed are ignored; abort beats start.
    start = 1;
    applyStimulus(0, 0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 24'h55);
    applyStimulus(1, 1, 24'hAB);
    checkOutput("t4_wr_cnt", 32'(wr_cnt), 32'd1);
    abort = 1; start = 1;
    applyStimulus(0, 0, '0);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_done", 32'(done), 32'd0);
    cpuRead(0, 'hAB);

    // Out-of-range read, then read of addr 2 colliding with a capture write.
    cpuRead(310, 0);
    start = 1;
    applyStimulus(0, 0, '0);
    applyStimulus(1, 1, 24'h100);
    applyStimulus(1, 0, 24'h101);
    cpu_rd = 1; cpu_adr = AW'(2);
    applyStimulus(1, 0, 24'h102);
    checkOutput("t5_rdw_old", 32'(cpu_data), 32'd302);
    cpuRead(2, 'h102);

    // Reset asserted on sample 50 of a capture.
    abort = 1;
    applyStimulus(0, 0, '0);
    start = 1;
    applyStimulus(0, 0, '0);
    applyStimulus(1, 1, '0);
    for (int i = 1; i < 50; i++) applyStimulus(1, 0, DW'(i));
    reset_x = 1;
    applyStimulus(1, 0, DW'(50));
    reset_x = 0;
    checkOutput("t6_vo", 32'(vo), 32'd0);
    checkOutput("t6_datao", 32'(datao), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_wr_cnt", 32'(wr_cnt), 32'd0);
    checkOutput("t6_wr_ptr", 32'(wr_ptr), 32'd0);
    checkOutput("t6_cpu_data", 32'(cpu_data), 32'd0);
    applyStimulus(1, 0, 24'h77);
    checkOutput("t6_vo_track", 32'(vo), 32'd1);
    checkOutput("t6_datao_track", 32'(datao), 32'h77);
    applyStimulus(0, 0, '0);
    checkOutput("t6_vo_low", 32'(vo), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nps_capmem.md
Name: nps_capmem

Overview:
- Parametrised frame-capture memory for NPS pipeline outputs.
- Sits at the tail of a stream stage. It passes the vi/fi/data stream through with one cycle of delay and stores one frame's samples into an internal RAM.
- A CPU reads the RAM back through a registered read port.
- Generalises the earlier output memory with the following:
  - arm/abort control
  - frame-synchronised capture start and end
  - one-shot or ring mode
  - overflow and status reporting
  - a read-valid strobe
  - safe handling of out-of-range addresses

Parameters:
DATA_WIDTH, 24, sample width in bits
DEPTH, 300, number of RAM entries (≥2)
ADR_WIDTH, 9, address width; must satisfy 2**ADR_WIDTH ≥ DEPTH

Ports:
clk  input  1  system clock, all logic on rising edge
reset_x  input  1  synchronous reset, active-high (asserted 1 resets on next rising clk edge)
start  input  1  pulse: arm capture (IDLE or DONE only)
abort  input  1  pulse: return to IDLE; RAM contents kept
ring  input  1  mode, sampled at arm: 0 = one-shot, 1 = ring (wrap)
vi  input  1  input sample valid
fi  input  1  frame-start flag, qualified by vi
datai  input  DATA_WIDTH  input sample
vo  output  1  vi delayed 1 cycle
fo  output  1  fi delayed 1 cycle
datao  output  DATA_WIDTH  datai delayed 1 cycle
busy  output  1  state is ARMED or CAPTURE
done  output  1  state is DONE
ovf  output  1  one-shot frame exceeded DEPTH (sticky until next arm/reset)
wrapped  output  1  ring mode wrapped at least once (sticky until next arm/reset)
wr_cnt  output  ADR_WIDTH+1  valid entries captured, saturates at DEPTH
wr_ptr  output  ADR_WIDTH  next write address
cpu_adr  input  ADR_WIDTH  CPU read address
cpu_rd  input  1  CPU read strobe
cpu_data  output  DATA_WIDTH  read data, registered
cpu_vld  output  1  pulse, cpu_data valid

Behaviour:
- Reset (reset_x=1 at clk edge):
  - state IDLE
  - vo, fo, datao, busy, done, ovf, wrapped, cpu_vld = 0
  - wr_cnt, wr_ptr, cpu_data = 0
  - RAM is not reset.
  - Reset mid-capture aborts immediately. Stored RAM contents are then undefined for verification purposes.
- Pass-through: vo/fo/datao are registered copies of vi/fi/datai in every state. Latency is 1 cycle.
- Sample events: "sof" = vi&fi; "smp" = vi.
- States IDLE, ARMED, CAPTURE, DONE.
  - IDLE/DONE + start: go to ARMED. Latch ring. Clear wr_cnt, wr_ptr, ovf, wrapped.
  - ARMED + sof: write datai to addr 0, wr_ptr=1, wr_cnt=1, go to CAPTURE.
  - ARMED + vi without fi: ignored.
  - CAPTURE + sof: frame ended. That sample is NOT written. Go to DONE.
  - CAPTURE + smp (fi=0):
    - wr_ptr < DEPTH-1: write at wr_ptr, wr_ptr+1, wr_cnt+1.
    - wr_ptr = DEPTH-1: write; then
      - one-shot: wr_cnt=DEPTH, go to DONE.
      - ring: wr_ptr=0, wrapped=1, wr_cnt saturates at DEPTH, stay in CAPTURE.
  - DONE + smp (one-shot, frame continues past DEPTH): ovf=1 on the first such non-sof sample of the captured frame. No write. ovf tracking stops at the next sof.
  - abort in any state: go to IDLE next cycle. Counters and flags hold.
  - abort and start in the same cycle: abort wins.
  - start in ARMED/CAPTURE: ignored.
- Writes occur only in the cases listed above. There is no write in IDLE/ARMED except the ARMED sof sample.
- CPU read:
  - cpu_rd=1 at edge N gives cpu_data = RAM[cpu_adr] and cpu_vld=1 at N+1.
  - cpu_vld=0 otherwise; cpu_data holds its last value.
  - cpu_adr ≥ DEPTH returns 0 with cpu_vld=1.
  - Read and write to the same address in the same cycle returns the old data.
  - Reads are permitted in any state.
- Widths:
  - wr_cnt never exceeds DEPTH.
  - wr_ptr never reaches DEPTH.
  - Address comparisons are unsigned.

Test Plan:
- Reset, then start, ring=0. Frame of 5 samples (sof, data 0x10..0x14), then sof. Required: done=1, wr_cnt=5, ovf=0. CPU reads addr 0..4 give 0x10..0x14, each with cpu_vld one cycle after cpu_rd.
- One-shot, DEPTH=300, frame of 302 samples. Required: DONE after sample 300, wr_cnt=300, ovf=1. RAM[299] holds sample 299; sample 300 is not written.
- Ring mode, DEPTH=300, frame of 305 samples (data = index), then sof. Required: wrapped=1, wr_cnt=300, wr_ptr=5, RAM[0..4]=300..304, RAM[5]=5, state DONE.
- Armed, vi=1 with fi=0 for 3 cycles, then sof with data 0xAB. Required: RAM[0]=0xAB, wr_cnt=1. Then abort and start asserted in the same cycle: state is IDLE, busy=0.
- cpu_rd with cpu_adr=310 (≥DEPTH). Required: cpu_data=0, cpu_vld=1. A read of addr 2 in the same cycle as a capture write to addr 2 returns the prior contents.
- reset_x=1 asserted mid-capture at sample 50. Required: all outputs 0 on the next cycle, state IDLE. vo tracks vi with 1-cycle delay again from the following cycle.
